// File: rtl/count_pkg.sv
// Shared definitions for the count checker: sample width, FSM encoding and
// the modulo-16 successor used to predict the next observed count.
package count_pkg;

  localparam int COUNT_W = 4;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Successor of a wrapping up-counter; 15 rolls over to 0.
  function automatic count_t next_count(input count_t c);
    return c + count_t'(1);
  endfunction

endpackage

// File: rtl/count_checker_if.sv
// Sample/result bundle between a count producer and the checker.
// master drives the samples and reads the status; slave is the checker.
interface count_checker_if #(
  parameter int ERR_W = 8
) ();

  logic                  en;
  count_pkg::count_t     count_in;
  logic                  clr;
  logic                  locked;
  logic                  err_pulse;
  logic                  err_sticky;
  logic [ERR_W-1:0]      err_cnt;
  logic                  wrap_pulse;
  count_pkg::count_t     expected;

  modport master (
    output en, count_in, clr,
    input  locked, err_pulse, err_sticky, err_cnt, wrap_pulse, expected
  );

  modport slave (
    input  en, count_in, clr,
    output locked, err_pulse, err_sticky, err_cnt, wrap_pulse, expected
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clr zeroes it.
module sat_counter
  import count_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Count up on inc until every bit is set; clr wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Checks a sampled 4-bit wrapping counter. Acquires lock after LOCK_N
// consecutive good transitions, reports mismatches while locked, and drops
// back to acquisition after UNLOCK_N consecutive mismatches.
module count_checker
  import count_pkg::*;
#(
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int ERR_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  count_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);

  state_t           state;
  count_t           expected_q;
  logic [3:0]       good_run;
  logic [3:0]       bad_run;
  logic             locked_q;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic             wrap_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic match;
  logic err_inc;

  assign match   = (bus.count_in == expected_q);
  // Only a mismatch seen in LOCKED counts as an error; clr overrides it.
  assign err_inc = bus.en && !bus.clr && (state == LOCKED) && !match;

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (bus.clr),
    .cnt   (err_cnt_q)
  );

  // Lock FSM with registered status outputs; clr has priority over en.
  // NOTE: reset is asynchronous assert only; rst_n deassertion is expected to
  // arrive already synchronised to clk, so no synchroniser is added here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      expected_q   <= '0;
      good_run     <= '0;
      bad_run      <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else if (bus.clr) begin
      state        <= IDLE;
      expected_q   <= '0;
      good_run     <= '0;
      bad_run      <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the values
      // from before this edge, so match/expected_q are the pre-edge values.
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (bus.en) begin
        // Always resync the prediction to what was actually observed.
        expected_q <= next_count(bus.count_in);
        unique case (state)
          IDLE: begin
            good_run <= '0;
            bad_run  <= '0;
            locked_q <= 1'b0;
            state    <= ACQ;
          end
          ACQ: begin
            if (match) begin
              if (good_run == LOCK_V - 4'd1) begin
                good_run <= LOCK_V;
                locked_q <= 1'b1;
                state    <= LOCKED;
              end else begin
                good_run <= good_run + 4'd1;
              end
            end else begin
              good_run <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              bad_run      <= '0;
              wrap_pulse_q <= (expected_q == '0);
            end else begin
              err_pulse_q  <= 1'b1;
              err_sticky_q <= 1'b1;
              if (bad_run == UNLOCK_V - 4'd1) begin
                bad_run  <= '0;
                good_run <= '0;
                locked_q <= 1'b0;
                state    <= ACQ;
              end else begin
                bad_run <= bad_run + 4'd1;
              end
            end
          end
          default: begin
            locked_q <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.expected   = expected_q;

endmodule
